// File: rtl/hwpe_ctrl_periph_responder.sv
// Responder end of the HWPE peripheral control port: register file, start/busy/done tracking.
// Optional HWPE_CTRL_PERIPH_ERR_EN adds err_o and a 32'hBADACCE5 pattern for out-of-range reads.
module hwpe_ctrl_periph_responder #(
   parameter int ID_WIDTH = 8,
   parameter int N_REGS   = 8,
   parameter int LATENCY  = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_i,
   output logic                       gnt_o,
   input  logic [31:0]                add_i,
   input  logic                       we_n_i,
   input  logic [3:0]                 be_i,
   input  logic [31:0]                data_i,
   input  logic [ID_WIDTH-1:0]        id_i,
   output logic [31:0]                r_data_o,
   output logic                       r_valid_o,
   output logic [ID_WIDTH-1:0]        r_id_o,
   output logic                       start_o,
   input  logic                       done_i,
   output logic                       busy_o,
`ifdef HWPE_CTRL_PERIPH_ERR_EN
   output logic                       err_o,
`endif
   output logic [32*(N_REGS-2)-1:0]   regs_o
);

   // state   | meaning
   // IDLE    | grant follows req_i, accept captures the transaction
   // WAIT    | latency padding, counter runs down to zero
   // RESP    | r_valid_o high for one cycle
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam int         NG       = N_REGS - 2;
   localparam logic [9:0] OFF_LIM  = 10'(N_REGS);
   localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  start_q, start_d;
   logic [31:0]           r_data_q, r_data_d;
   logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic [31:0]           pend_data_q, pend_data_d;
   logic [ID_WIDTH-1:0]   pend_id_q, pend_id_d;
   logic [31:0]           gen_q [NG];
   logic [31:0]           gen_d [NG];

   logic [9:0]            offset;
   logic                  in_range;
   logic                  accept;
   logic [31:0]           rd_val;
   logic                  unused_addr;

   assign offset      = add_i[11:2];
   assign in_range    = offset < OFF_LIM;
   assign unused_addr = ^{add_i[31:12], add_i[1:0]};

   always_comb begin
      rd_val = '0;
      if (we_n_i) begin
`ifdef HWPE_CTRL_PERIPH_ERR_EN
         if (!in_range) rd_val = 32'hBADACCE5;
`endif
         if (offset == 10'd1) rd_val = {31'b0, busy_q};
         for (int i = 0; i < NG; i++) begin
            if (offset == 10'(i + 2)) rd_val = gen_q[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      start_d     = 1'b0;
      r_data_d    = r_data_q;
      r_id_d      = r_id_q;
      pend_data_d = pend_data_q;
      pend_id_d   = pend_id_q;
      gen_d       = gen_q;
      gnt_o       = 1'b0;
      accept      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            gnt_o  = req_i;
            accept = req_i;
            if (accept) begin
               pend_data_d = rd_val;
               pend_id_d   = id_i;
               cnt_d       = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d  = ST_RESP;
                  r_data_d = rd_val;
                  r_id_d   = id_i;
               end else begin
                  state_d  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d  = ST_RESP;
               r_data_d = pend_data_q;
               r_id_d   = pend_id_q;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (done_i && busy_q) busy_d = 1'b0;

      // busy_q is the pre-accept value, so a trigger racing done_i is dropped
      if (accept && !we_n_i && !busy_q) begin
         if (offset == 10'd0 && |be_i) begin
            busy_d  = 1'b1;
            start_d = 1'b1;
         end
         for (int i = 0; i < NG; i++) begin
            if (offset == 10'(i + 2)) begin
               for (int b = 0; b < 4; b++) begin
                  if (be_i[b]) gen_d[i][8*b +: 8] = data_i[8*b +: 8];
               end
            end
         end
      end
   end

`ifdef HWPE_CTRL_PERIPH_ERR_EN
   logic err_pend_q, err_pend_d;

   always_comb begin
      err_pend_d = err_pend_q;
      if (accept) err_pend_d = !in_range || (!we_n_i && busy_q && offset != 10'd1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) err_pend_q <= 1'b0;
      else       err_pend_q <= err_pend_d;
   end

   assign err_o = (state_q == ST_RESP) && err_pend_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 2'd0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         r_data_q    <= '0;
         r_id_q      <= '0;
         pend_data_q <= '0;
         pend_id_q   <= '0;
         for (int i = 0; i < NG; i++) gen_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         r_data_q    <= r_data_d;
         r_id_q      <= r_id_d;
         pend_data_q <= pend_data_d;
         pend_id_q   <= pend_id_d;
         gen_q       <= gen_d;
      end
   end

   for (genvar g = 0; g < NG; g++) begin : g_regs
      assign regs_o[32*g +: 32] = gen_q[g];
   end

   assign r_data_o  = r_data_q;
   assign r_id_o    = r_id_q;
   assign r_valid_o = (state_q == ST_RESP);
   assign start_o   = start_q;
   assign busy_o    = busy_q;

endmodule
